pipe_flow_ctrl_sv: RTL and testbench

Valid/ready flow controller for a free-running, fixed-latency datapath, e.g. fixed_delay_line_sv or a retimed pipeline_sv with Enable tied high.
- Accepts words from an upstream valid/ready source and launches them into the external datapath.
- Tracks in-flight words with a tag shift register and captures returned results into an internal FIFO.
- Uses credit counting, so it never accepts a word it cannot store.
- Supports a flush/drain sequence for reconfiguration, e.g. before changing a delay-line tap address.

---
 rtl/pipe_flow_ctrl_sv.sv | 192 +++++++++++++++++++
 tb/tb_pipe_flow_ctrl_sv.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl_sv.sv
`default_nettype none
// ============================================================================
// Module      : pipe_flow_ctrl_sv
// Description : Valid/ready flow controller for a free-running, fixed-latency
//               external datapath. Accepted words are launched into the
//               datapath. A tag shift register marks which datapath outputs
//               carry real results, and those results are captured into an
//               internal FIFO. A credit counter covers both the in-flight
//               words and the buffered words, so a word is only accepted when
//               there is guaranteed room to store its result. A Flush request
//               stops intake, waits until every credit is returned, and then
//               pulses Flush_done.
//
// Ports       : Clock          system clock
//               Reset          synchronous reset, active-low
//               In_valid       upstream word valid
//               In_ready       controller can accept a word
//               In_data        upstream word
//               Pipe_data_in   datapath input (equals In_data)
//               Pipe_valid_in  launch strobe (In_valid & In_ready)
//               Pipe_data_out  datapath output, LATENCY cycles after launch
//               Out_valid      result FIFO non-empty
//               Out_ready      downstream ready
//               Out_data       result FIFO head
//               Flush          drain request, sampled only in RUN
//               Flush_done     one-cycle pulse when the drain completes
//               Stall_count    (optional) saturating count of stalled cycles
//
// Options     : define PIPE_FLOW_CTRL_STATS_EN to add the Stall_count output
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_flow_ctrl_sv #(
    parameter int WORD_LENGTH = 8,
    parameter int LATENCY     = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [WORD_LENGTH-1:0] In_data,
    output logic [WORD_LENGTH-1:0] Pipe_data_in,
    output logic                   Pipe_valid_in,
    input  logic [WORD_LENGTH-1:0] Pipe_data_out,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [WORD_LENGTH-1:0] Out_data,
    input  logic                   Flush,
    output logic                   Flush_done
`ifdef PIPE_FLOW_CTRL_STATS_EN
    ,
    output logic [31:0]            Stall_count
`endif
);

    generate
        if (WORD_LENGTH < 1) begin : g_chk_word_length
            $error("pipe_flow_ctrl_sv: WORD_LENGTH must be > 0");
        end
        if (LATENCY < 1) begin : g_chk_latency
            $error("pipe_flow_ctrl_sv: LATENCY must be >= 1");
        end
        if (FIFO_DEPTH < 2) begin : g_chk_fifo_depth
            $error("pipe_flow_ctrl_sv: FIFO_DEPTH must be >= 2");
        end
    endgenerate

    localparam int              c_UW       = $clog2(FIFO_DEPTH + 1);
    localparam int              c_PW       = $clog2(FIFO_DEPTH);
    localparam logic [c_UW-1:0] c_DEPTH    = c_UW'(FIFO_DEPTH);
    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LATENCY-1:0]     r_tag;
    logic [c_UW-1:0]        r_used;
    logic [c_UW-1:0]        r_count;
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [WORD_LENGTH-1:0] r_mem [FIFO_DEPTH];

    logic w_accept;
    logic w_pop;
    logic w_ret;

    // The Reset gating keeps every handshake output quiet during the reset
    // cycle, even before the registers have taken their cleared values.
    assign In_ready      = Reset & (r_state == ST_RUN) & (r_used < c_DEPTH);
    assign w_accept      = In_valid & In_ready;
    assign Pipe_valid_in = w_accept;
    assign Pipe_data_in  = In_data;
    assign w_ret         = r_tag[LATENCY-1];
    assign Out_valid     = Reset & (r_count != '0);
    assign w_pop         = Out_valid & Out_ready;
    assign Out_data      = r_mem[r_rd_ptr];
    assign Flush_done    = Reset & (r_state == ST_DONE);

    // One tag bit per datapath stage. The datapath itself has no valid
    // signal, so this shift register is what marks real results on its output.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_tag <= '0;
        end else begin
            r_tag[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Credits cover in-flight plus buffered words. A return only moves a word
    // from the datapath into the FIFO, so it leaves the total unchanged.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_used <= '0;
        end else if (w_accept && !w_pop) begin
            r_used <= r_used + c_UW'(1);
        end else if (!w_accept && w_pop) begin
            r_used <= r_used - c_UW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && w_ret) begin
            r_mem[r_wr_ptr] <= Pipe_data_out;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_ret) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PW'(1);
            end
            if (w_ret && !w_pop) begin
                r_count <= r_count + c_UW'(1);
            end else if (!w_ret && w_pop) begin
                r_count <= r_count - c_UW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (Flush) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_used == '0) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

`ifdef PIPE_FLOW_CTRL_STATS_EN
    logic [31:0] r_stall_count;

    // Only stalls caused by back-pressure in RUN are counted. Intake that is
    // closed by a drain is intentional, so it is not counted as a stall.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_stall_count <= '0;
        end else if (In_valid && !In_ready && (r_state == ST_RUN) &&
                     (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign Stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl_sv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_flow_ctrl_sv
// Description : Self-checking bench for pipe_flow_ctrl_sv. Two instances are
//               used: A (LATENCY=4, FIFO_DEPTH=8) and B (LATENCY=1,
//               FIFO_DEPTH=2). Each is paired with a plain delay-line model
//               of its datapath. Accepted words are pushed to a scoreboard
//               queue, and they are popped and compared when the controller
//               delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_flow_ctrl_sv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A ----------------
    logic       a_rst, a_iv, a_ir, a_pvi, a_ov, a_or, a_fl, a_fd;
    logic [7:0] a_id, a_pdi, a_pdo, a_od;
    logic [7:0] a_dly [4];
`ifdef PIPE_FLOW_CTRL_STATS_EN
    logic [31:0] a_stall;
`endif

    pipe_flow_ctrl_sv #(.WORD_LENGTH(8), .LATENCY(4), .FIFO_DEPTH(8)) u_dut_a (
        .Clock(clk), .Reset(a_rst), .In_valid(a_iv), .In_ready(a_ir),
        .In_data(a_id), .Pipe_data_in(a_pdi), .Pipe_valid_in(a_pvi),
        .Pipe_data_out(a_pdo), .Out_valid(a_ov), .Out_ready(a_or),
        .Out_data(a_od), .Flush(a_fl), .Flush_done(a_fd)
`ifdef PIPE_FLOW_CTRL_STATS_EN
        , .Stall_count(a_stall)
`endif
    );

    always @(posedge clk) begin
        a_dly[0] <= a_pdi;
        for (int i = 1; i < 4; i++) a_dly[i] <= a_dly[i-1];
    end
    assign a_pdo = a_dly[3];

    // ---------------- instance B ----------------
    logic       b_rst, b_iv, b_ir, b_pvi, b_ov, b_or, b_fl, b_fd;
    logic [7:0] b_id, b_pdi, b_pdo, b_od, b_dly;
`ifdef PIPE_FLOW_CTRL_STATS_EN
    logic [31:0] b_stall;
`endif

    pipe_flow_ctrl_sv #(.WORD_LENGTH(8), .LATENCY(1), .FIFO_DEPTH(2)) u_dut_b (
        .Clock(clk), .Reset(b_rst), .In_valid(b_iv), .In_ready(b_ir),
        .In_data(b_id), .Pipe_data_in(b_pdi), .Pipe_valid_in(b_pvi),
        .Pipe_data_out(b_pdo), .Out_valid(b_ov), .Out_ready(b_or),
        .Out_data(b_od), .Flush(b_fl), .Flush_done(b_fd)
`ifdef PIPE_FLOW_CTRL_STATS_EN
        , .Stall_count(b_stall)
`endif
    );

    always @(posedge clk) b_dly <= b_pdi;
    assign b_pdo = b_dly;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboards ----------------
    logic [7:0] a_q [$];
    logic [7:0] b_q [$];

    always @(negedge clk) begin
        if (!a_rst) begin
            a_q.delete();
        end else begin
            if (a_ov && a_or) begin
                chk("a_pop_has_entry", 32'(a_q.size() != 0), 32'd1);
                if (a_q.size() != 0) chk("a_out_data", 32'(a_od), 32'(a_q.pop_front()));
            end
            if (a_iv && a_ir) begin
                a_q.push_back(a_id);
                chk("a_credit_bound", 32'(a_q.size() <= 8), 32'd1);
            end
        end
    end

    // B never flushes, so its In_ready must equal the credit model exactly:
    // the queue length at this point is the in-flight plus buffered count.
    always @(negedge clk) begin
        chk("b_in_ready", 32'(b_ir), 32'(b_rst && (b_q.size() < 2)));
        if (!b_rst) begin
            b_q.delete();
        end else begin
            if (b_ov && b_or) begin
                chk("b_pop_has_entry", 32'(b_q.size() != 0), 32'd1);
                if (b_q.size() != 0) chk("b_out_data", 32'(b_od), 32'(b_q.pop_front()));
            end
            if (b_iv && b_ir) b_q.push_back(b_id);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        int  sent;
        logic b_need_new;

        a_rst = 0; a_iv = 1; a_id = 8'h00; a_or = 0; a_fl = 0;
        b_rst = 0; b_iv = 1; b_id = 8'h00; b_or = 0; b_fl = 0;

        // 1: reset held with In_valid high
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_in_ready", 32'(a_ir), 32'd0);
            chk("t1_out_valid", 32'(a_ov), 32'd0);
            chk("t1_pipe_valid", 32'(a_pvi), 32'd0);
            chk("t1_flush_done", 32'(a_fd), 32'd0);
        end
        next_cycle();
        a_rst = 1; b_rst = 1; b_iv = 0;

        // 2: ten back-to-back words, Out_valid from cycle 5 through 14
        for (int c = 0; c < 17; c++) begin
            a_or = 1; a_iv = (c < 10); a_id = 8'(c + 1);
            @(negedge clk);
            if (c < 10) chk("t2_in_ready", 32'(a_ir), 32'd1);
            chk("t2_out_valid", 32'(a_ov), 32'((c >= 5) && (c <= 14)));
            if (a_ov) chk("t2_out_data", 32'(a_od), 32'(c - 4));
            next_cycle();
        end

        // 3: back-pressure fills all credits
        a_or = 0; n = 0;
        for (int c = 0; c < 16; c++) begin
            a_iv = 1; a_id = 8'h20 + 8'(n);
            @(negedge clk);
            if (a_iv && a_ir) n++;
            next_cycle();
        end
        a_iv = 0;
        @(negedge clk);
        chk("t3_accepted", 32'(n), 32'd8);
        chk("t3_in_ready_full", 32'(a_ir), 32'd0);
        next_cycle();
        a_or = 1;
        @(negedge clk);
        chk("t3_first_pop_valid", 32'(a_ov), 32'd1);
        chk("t3_in_ready_at_pop", 32'(a_ir), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t3_in_ready_after_pop", 32'(a_ir), 32'd1);
        for (int c = 0; c < 10; c++) next_cycle();
        @(negedge clk);
        chk("t3_drained", 32'(a_q.size()), 32'd0);
        chk("t3_out_valid_idle", 32'(a_ov), 32'd0);
        next_cycle();

        // 4: instance B, 50 random words with continuous In_valid/Out_ready
        b_or = 1; sent = 0; b_need_new = 1;
        for (int c = 0; c < 300 && sent < 50; c++) begin
            b_iv = 1;
            if (b_need_new) b_id = 8'($urandom);
            @(negedge clk);
            b_need_new = b_ir;
            if (b_ir) sent++;
            next_cycle();
        end
        b_iv = 0;
        chk("t4_sent", 32'(sent), 32'd50);
        for (int c = 0; c < 6; c++) next_cycle();
        @(negedge clk);
        chk("t4_all_delivered", 32'(b_q.size()), 32'd0);
        chk("t4_out_valid_idle", 32'(b_ov), 32'd0);
        next_cycle();

        // 5: flush with three words in flight (last one in the Flush cycle)
        a_or = 1;
        for (int c = 0; c < 12; c++) begin
            a_iv = 1; a_id = 8'h30 + 8'(c); a_fl = (c == 2);
            @(negedge clk);
            chk("t5_in_ready", 32'(a_ir), 32'((c <= 2) || (c >= 10)));
            chk("t5_flush_done", 32'(a_fd), 32'(c == 9));
            next_cycle();
        end
        a_iv = 0; a_fl = 0;
        for (int c = 0; c < 8; c++) next_cycle();
        @(negedge clk);
        chk("t5_drained", 32'(a_q.size()), 32'd0);
        next_cycle();
        // flush with nothing outstanding: Flush_done two cycles later
        a_fl = 1;
        @(negedge clk);
        chk("t5e_fd_c0", 32'(a_fd), 32'd0);
        next_cycle();
        a_fl = 0;
        @(negedge clk);
        chk("t5e_fd_c1", 32'(a_fd), 32'd0);
        chk("t5e_in_ready_c1", 32'(a_ir), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t5e_fd_c2", 32'(a_fd), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t5e_fd_c3", 32'(a_fd), 32'd0);
        chk("t5e_in_ready_c3", 32'(a_ir), 32'd1);
        next_cycle();

        // 6: reset with 4 words in flight and 2 buffered
        a_or = 0;
        for (int c = 0; c < 6; c++) begin
            a_iv = 1; a_id = 8'h60 + 8'(c);
            @(negedge clk);
            chk("t6_fill_ready", 32'(a_ir), 32'd1);
            next_cycle();
        end
        a_iv = 0; a_rst = 0;
        @(negedge clk);
        chk("t6_rst_out_valid", 32'(a_ov), 32'd0);
        chk("t6_rst_in_ready", 32'(a_ir), 32'd0);
        next_cycle();
        a_rst = 1; a_or = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_no_stale", 32'(a_ov), 32'd0);
            next_cycle();
        end
        a_iv = 1; a_id = 8'h55;
        @(negedge clk);
        chk("t6_new_ready", 32'(a_ir), 32'd1);
        next_cycle();
        a_iv = 0;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            chk("t6_new_not_yet", 32'(a_ov), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("t6_new_valid", 32'(a_ov), 32'd1);
        chk("t6_new_data", 32'(a_od), 32'h55);
        next_cycle();
        for (int c = 0; c < 3; c++) next_cycle();

        @(negedge clk);
        chk("final_a_empty", 32'(a_q.size()), 32'd0);
        chk("final_b_empty", 32'(b_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
